// File: rtl/taxi_apb_reg_slave.sv
// taxi_apb_reg_slave
//   APB completer with a bank of REG_COUNT read/write registers. The register
//   contents are exported to fabric logic, together with per-register
//   write and read pulses.
//   Each APB transfer has a setup cycle and an access phase. The access phase
//   can be stretched by WAIT_STATES cycles. Byte strobes are honoured.
//   An index beyond the bank is answered with pslverr when ERR_EN=1, and is
//   otherwise silently ignored.
//   pprot/pauser/pwuser carry nothing this block uses, so they are not ports.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   s_apb_paddr      byte address; register index = paddr >> log2(STRB_W)
//   s_apb_psel/penable/pwrite/pwdata/pstrb   APB request
//   s_apb_pready/prdata/pslverr              APB response
//   reg_q            register contents, reg i at [i*DATA_W +: DATA_W]
//   reg_wr           one-hot pulse, the cycle after reg i took a write
//   reg_rd           one-hot pulse, the cycle after reg i was read

// One register. The byte lanes are written independently under the strobe.
module taxi_apb_reg_slave_reg #(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W/8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] strb,
  output logic [DATA_W-1:0] q
);

  for (genvar b = 0; b < STRB_W; b++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        q[b*8 +: 8] <= RESET_VAL[b*8 +: 8];
      else if (we && strb[b])
        q[b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

endmodule

module taxi_apb_reg_slave #(
  parameter int REG_COUNT   = 16,
  parameter int WAIT_STATES = 0,
  parameter int ERR_EN      = 1,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int STRB_W      = DATA_W/8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           s_apb_paddr,
  input  logic                        s_apb_psel,
  input  logic                        s_apb_penable,
  input  logic                        s_apb_pwrite,
  input  logic [DATA_W-1:0]           s_apb_pwdata,
  input  logic [STRB_W-1:0]           s_apb_pstrb,
  output logic                        s_apb_pready,
  output logic [DATA_W-1:0]           s_apb_prdata,
  output logic                        s_apb_pslverr,
  output logic [REG_COUNT*DATA_W-1:0] reg_q,
  output logic [REG_COUNT-1:0]        reg_wr,
  output logic [REG_COUNT-1:0]        reg_rd
);

  localparam int IDX_LSB = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(REG_COUNT);
  localparam logic [3:0] WS  = 4'(WAIT_STATES);
  localparam logic       ERR = (ERR_EN != 0);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              wr;
    logic              oor;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } req_t;

  logic [0:0]  state;
  req_t        req_in, req_q;
  logic [3:0]  cnt;
  logic        pready_q, pslverr_q;
  logic [DATA_W-1:0] prdata_q;
  logic        oor_in, done;
  logic [REG_COUNT-1:0] onehot, we;
  logic [REG_COUNT-1:0][DATA_W-1:0] regs;

  // Any address bit above the index field selects a register that does not exist.
  if (ADDR_W > IDX_LSB + IDX_W) begin : g_oor
    assign oor_in = |s_apb_paddr[ADDR_W-1:IDX_LSB+IDX_W];
  end else begin : g_no_oor
    assign oor_in = 1'b0;
  end

  // The byte offset inside a register has no meaning to the bank.
  if (IDX_LSB > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^s_apb_paddr[IDX_LSB-1:0];
  end

  assign req_in = '{idx:   s_apb_paddr[IDX_LSB +: IDX_W],
                    wr:    s_apb_pwrite,
                    oor:   oor_in,
                    wdata: s_apb_pwdata,
                    strb:  s_apb_pstrb};

  assign done   = (state == ACCESS) && s_apb_psel && s_apb_penable && pready_q;
  assign onehot = REG_COUNT'(1) << req_q.idx;
  // Commit on the completion edge. An out-of-range write touches nothing.
  assign we     = (done && req_q.wr && !req_q.oor) ? onehot : '0;

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
    taxi_apb_reg_slave_reg #(
      .DATA_W   (DATA_W),
      .STRB_W   (STRB_W),
      .RESET_VAL(RESET_VAL)
    ) u_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (we[i]),
      .wdata(req_q.wdata),
      .strb (req_q.strb),
      .q    (regs[i])
    );
  end

  assign reg_q         = regs;
  assign s_apb_pready  = pready_q;
  assign s_apb_pslverr = pslverr_q;
  // Read data is captured at setup. It is visible only while pready is high.
  assign s_apb_prdata  = pready_q ? prdata_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= '0;
      cnt       <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      reg_wr    <= '0;
      reg_rd    <= '0;
    end else begin
      reg_wr <= we;
      reg_rd <= (done && !req_q.wr && !req_q.oor) ? onehot : '0;
      case (state)
        IDLE: begin
          if (s_apb_psel && !s_apb_penable) begin
            req_q     <= req_in;
            cnt       <= WS;
            pready_q  <= (WS == 4'd0);
            pslverr_q <= (WS == 4'd0) && ERR && oor_in;
            prdata_q  <= (!s_apb_pwrite && !oor_in) ? regs[req_in.idx] : '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!s_apb_psel || done) begin
            // Requester abandoned the transfer, or it completed: back to idle.
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            state     <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              pready_q  <= 1'b1;
              pslverr_q <= ERR && req_q.oor;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_taxi_apb_reg_slave.sv
// Bench for taxi_apb_reg_slave. It has two instances:
//   u0: WAIT_STATES=0, ERR_EN=1
//   u1: WAIT_STATES=3, ERR_EN=0
// Both use RESET_VAL=32'hA5A5_0000.
module tb_taxi_apb_reg_slave;
  localparam int RC = 16, DW = 32, AW = 16, SW = 4;
  localparam logic [31:0] RV = 32'hA5A5_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    paddr[2];
  logic             psel[2], penable[2], pwrite[2];
  logic [DW-1:0]    pwdata[2];
  logic [SW-1:0]    pstrb[2];
  logic             pready[2], pslverr[2];
  logic [DW-1:0]    prdata[2];
  logic [RC*DW-1:0] reg_q[2];
  logic [RC-1:0]    reg_wr[2], reg_rd[2];

  taxi_apb_reg_slave #(.REG_COUNT(RC), .WAIT_STATES(0), .ERR_EN(1), .DATA_W(DW),
    .ADDR_W(AW), .STRB_W(SW), .RESET_VAL(RV)) u0 (
    .clk(clk), .rst_n(rst_n), .s_apb_paddr(paddr[0]), .s_apb_psel(psel[0]),
    .s_apb_penable(penable[0]), .s_apb_pwrite(pwrite[0]), .s_apb_pwdata(pwdata[0]),
    .s_apb_pstrb(pstrb[0]), .s_apb_pready(pready[0]), .s_apb_prdata(prdata[0]),
    .s_apb_pslverr(pslverr[0]), .reg_q(reg_q[0]), .reg_wr(reg_wr[0]), .reg_rd(reg_rd[0]));

  taxi_apb_reg_slave #(.REG_COUNT(RC), .WAIT_STATES(3), .ERR_EN(0), .DATA_W(DW),
    .ADDR_W(AW), .STRB_W(SW), .RESET_VAL(RV)) u1 (
    .clk(clk), .rst_n(rst_n), .s_apb_paddr(paddr[1]), .s_apb_psel(psel[1]),
    .s_apb_penable(penable[1]), .s_apb_pwrite(pwrite[1]), .s_apb_pwdata(pwdata[1]),
    .s_apb_pstrb(pstrb[1]), .s_apb_pready(pready[1]), .s_apb_prdata(prdata[1]),
    .s_apb_pslverr(pslverr[1]), .reg_q(reg_q[1]), .reg_wr(reg_wr[1]), .reg_rd(reg_rd[1]));

  int n_chk = 0, n_fail = 0;
  logic [31:0] mdl[2][RC];

  typedef struct {
    int          d;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] rd;
    logic        err;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] bank(input int d);
    logic [511:0] b;
    for (int i = 0; i < RC; i++) b[i*32 +: 32] = mdl[d][i];
    return b;
  endfunction

  function automatic logic [511:0] rst_bank();
    logic [511:0] b;
    for (int i = 0; i < RC; i++) b[i*32 +: 32] = RV;
    return b;
  endfunction

  task automatic mdl_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < RC; i++) mdl[d][i] = RV;
  endtask

  task automatic bus_idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
  endtask

  // Runs one full APB transfer on instance d.
  // The outcome is checked against the model, which is then updated.
  task automatic xfer(input int d, input logic wr, input logic [15:0] addr,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic err);
    int lat, idx, ws;
    logic oor, errx;
    logic [31:0] exp_rd;
    logic [15:0] exp_1h;
    idx  = int'(addr >> 2);
    oor  = (idx >= RC);
    ws   = (d == 0) ? 0 : 3;
    errx = oor && (d == 0);
    exp_rd = 32'h0;
    if (!wr && !oor) exp_rd = mdl[d][idx];
    exp_1h = 16'h0;
    if (!oor) exp_1h = 16'h1 << idx;

    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wd; pstrb[d] = st;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    lat = 1;
    while (!pready[d] && lat < 40) begin
      chk("prdata_zero_in_wait", 512'(prdata[d]), 512'(0));
      @(posedge clk); #1;
      lat++;
    end
    chk("pready_latency", 512'(lat), 512'(ws + 1));
    rd  = prdata[d];
    err = pslverr[d];
    chk("prdata", 512'(rd), 512'(exp_rd));
    chk("pslverr", 512'(err), 512'(errx));
    @(posedge clk); #1;
    bus_idle(d);
    chk("pready_after_done", 512'(pready[d]), 512'(0));
    chk("reg_wr", 512'(reg_wr[d]), 512'(wr ? exp_1h : 16'h0));
    chk("reg_rd", 512'(reg_rd[d]), 512'(wr ? 16'h0 : exp_1h));
    if (wr && !oor)
      for (int b = 0; b < 4; b++)
        if (st[b]) mdl[d][idx][b*8 +: 8] = wd[b*8 +: 8];
    chk("reg_q", reg_q[d], bank(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic err;

    vt[0]  = '{0, 1'b1, 16'h0008, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vt[1]  = '{0, 1'b0, 16'h0008, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{0, 1'b1, 16'h0004, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
    vt[3]  = '{0, 1'b1, 16'h0004, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0};
    vt[4]  = '{0, 1'b0, 16'h0004, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vt[5]  = '{0, 1'b1, 16'h0004, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
    vt[6]  = '{0, 1'b0, 16'h0004, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vt[7]  = '{0, 1'b1, 16'h0040, 32'h1234_5678, 4'hF, 32'h0, 1'b1};
    vt[8]  = '{0, 1'b0, 16'h0040, 32'h0,         4'h0, 32'h0, 1'b1};
    vt[9]  = '{1, 1'b0, 16'h0004, 32'h0,         4'h0, 32'hA5A5_0000, 1'b0};
    vt[10] = '{1, 1'b1, 16'h0040, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
    vt[11] = '{1, 1'b0, 16'h0040, 32'h0,         4'h0, 32'h0, 1'b0};
    vt[12] = '{1, 1'b1, 16'h003C, 32'h0000_BEEF, 4'h3, 32'h0, 1'b0};
    vt[13] = '{1, 1'b0, 16'h003C, 32'h0,         4'h0, 32'hA5A5_BEEF, 1'b0};

    bus_idle(0); bus_idle(1);
    mdl_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state on both instances.
    for (int d = 0; d < 2; d++) begin
      chk("rst_reg_q", reg_q[d], rst_bank());
      chk("rst_pready", 512'(pready[d]), 512'(0));
      chk("rst_pslverr", 512'(pslverr[d]), 512'(0));
      chk("rst_prdata", 512'(prdata[d]), 512'(0));
      chk("rst_reg_wr", 512'(reg_wr[d]), 512'(0));
      chk("rst_reg_rd", 512'(reg_rd[d]), 512'(0));
    end

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      xfer(vt[i].d, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].st, rd, err);
      chk($sformatf("vec%0d_rd", i), 512'(rd), 512'(vt[i].rd));
      chk($sformatf("vec%0d_err", i), 512'(err), 512'(vt[i].err));
    end
    @(posedge clk); #1;
    chk("strobe_one_cycle_wr", 512'(reg_wr[1]), 512'(0));
    chk("strobe_one_cycle_rd", 512'(reg_rd[1]), 512'(0));

    // Abort: psel drops partway through the wait states of a write.
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 16'h0010; pwdata[1] = 32'h0BAD_F00D; pstrb[1] = 4'hF;
    @(posedge clk); #1 penable[1] = 1'b1;
    @(posedge clk); #1 bus_idle(1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("abort_no_wr", 512'(reg_wr[1]), 512'(0));
      chk("abort_no_pready", 512'(pready[1]), 512'(0));
    end
    chk("abort_reg_q", reg_q[1], bank(1));
    xfer(1, 1'b0, 16'h0010, 32'h0, 4'h0, rd, err);

    // Reset asserted during the access phase of a write.
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 16'h0008; pwdata[0] = 32'h1234_5678; pstrb[0] = 4'hF;
    @(posedge clk); #1 penable[0] = 1'b1;
    #2 rst_n = 1'b0;
    bus_idle(0);
    #1;
    mdl_reset();
    chk("midrst_pready", 512'(pready[0]), 512'(0));
    chk("midrst_reg_q0", reg_q[0], rst_bank());
    chk("midrst_reg_q1", reg_q[1], rst_bank());
    chk("midrst_reg_wr", 512'(reg_wr[0]), 512'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_reg_q", reg_q[0], rst_bank());
    xfer(0, 1'b1, 16'h0008, 32'hCAFE_F00D, 4'hF, rd, err);
    xfer(0, 1'b0, 16'h0008, 32'h0, 4'h0, rd, err);
    chk("post_rst_read", 512'(rd), 512'(32'hCAFE_F00D));

    // Random traffic. Addresses up to 0x7F include out-of-range indices.
    for (int i = 0; i < 80; i++) begin
      xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 127)), $urandom, 4'($urandom_range(0, 15)), rd, err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
